keycode_move_decoder: RTL and testbench
=======================================

KEYCODE_MOVE_DECODER -- requirements
Module: keycode_move_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: clk cycles a nonzero keycode must hold before acceptance; legal range 1..65535.
REQ-002 Parameter DEPTH, default 8: move FIFO depth; power of two, minimum 2.
REQ-003 clk  input  1  system clock; MAX10_CLK1_50 domain, the same clock as the keycode PIO.
REQ-004 Reset_h  input  1  synchronous, active-high reset.
REQ-005 keycode  input  8  raw USB HID keycode from the NIOS PIO; 0x00 means no key.
REQ-006 move_valid  output  1  head-of-FIFO move available.
REQ-007 move_ready  input  1  rotation engine accepts the move; transfer occurs when move_valid and move_ready are both high.
REQ-008 move_face  output  3  face of the head move: U=0, D=1, F=2, B=3, L=4, R=5.
REQ-009 move_prime  output  1  head move is counter-clockwise.
REQ-010 prime_mode  output  1  current modal prime latch.
REQ-011 overflow  output  1  sticky flag; a face press was dropped because the FIFO was full.
REQ-012 fifo_count  output  $clog2(DEPTH)+1  number of queued moves.
REQ-013 move_count  output  16  total completed transfers; wraps from 0xFFFF to 0x0000.

Function
REQ-014 keycode shall be registered once (keycode_r) before any decision is made on it.
REQ-015 The key tracker FSM shall have three states: IDLE, SETTLE and HELD.
REQ-016 IDLE: if keycode_r is nonzero, go to SETTLE and clear the stability counter.
REQ-017 SETTLE, keycode_r changes to 0x00: go to IDLE.
REQ-018 SETTLE, keycode_r changes to a different nonzero value: stay in SETTLE and clear the counter.
REQ-019 SETTLE, counter equals STABLE_CYCLES-1 with keycode_r unchanged: accept the key and go to HELD.
REQ-020 SETTLE, otherwise: increment the counter.
REQ-021 HELD: keycode_r to 0x00 goes to IDLE; keycode_r to a different nonzero value goes to SETTLE with the counter cleared; an unchanged key never re-accepts (no autorepeat).
REQ-022 Accepted keys 0x18 U, 0x07 D, 0x09 F, 0x05 B, 0x0F L and 0x15 R shall enqueue {prime_mode, face}.
REQ-023 Accepted key 0x13 (P) shall toggle prime_mode; prime_mode affects only later enqueues, never moves already queued.
REQ-024 Accepted key 0x29 (Esc) shall flush the FIFO, making fifo_count 0 on the next cycle.
REQ-025 All other accepted keys shall be ignored.
REQ-026 Latency: with an empty FIFO, move_valid shall rise exactly STABLE_CYCLES+2 clk edges after keycode first presents a face key.
REQ-027 move_valid = (fifo_count != 0); move_face and move_prime shall reflect the head entry combinationally from FIFO storage and hold stable while move_valid is high and move_ready is low.
REQ-028 Full FIFO with no transfer that cycle: a face enqueue is dropped and overflow is set.
REQ-029 Full FIFO with a transfer in the same cycle: the enqueue succeeds and fifo_count is unchanged.
REQ-030 Empty FIFO: move_ready has no effect and move_count does not change.
REQ-031 Flush and transfer in the same cycle: the transfer counts in move_count, and the FIFO ends empty.
REQ-032 overflow shall clear only on reset or on an accepted Esc.
REQ-033 Read and write pointers shall wrap modulo DEPTH.

Reset
REQ-034 Reset_h high at a clk edge shall force: FSM to IDLE, stability counter to 0, keycode_r to 0x00, FIFO pointers and fifo_count to 0, move_valid 0, prime_mode 0, overflow 0, move_count 0.
REQ-035 Reset mid-SETTLE or mid-transfer shall discard all state; a key held through reset is re-qualified from IDLE with the full STABLE_CYCLES.

Structure
REQ-036 A shared package cube_pkg shall hold the face_t enum (U, D, F, B, L, R), the move_t struct {prime, face} and the keycode constants listed under Function.
REQ-037 The FIFO shall be one sub-module, move_fifo, parameterized by DEPTH and carrying move_t with push, pop, flush, full, empty and count ports; the FSM and counters stay in the top.

Verification (STABLE_CYCLES=4, DEPTH=4)
REQ-038 Hold 0x15 for 10 cycles with move_ready=0 -> move_valid rises on edge 6; face=5, prime=0; exactly one entry queued.
REQ-039 0x15 held 2 cycles then 0x00 (glitch) -> nothing enqueued; FSM returns to IDLE.
REQ-040 Press P, release, then press 0x18 -> prime_mode=1; head entry {1, U}.
REQ-041 Six distinct face presses with move_ready=0 -> fifo_count=4, overflow=1; then Esc -> fifo_count=0, overflow=0.
REQ-042 FIFO full with move_ready=1 and a new face accepted in the same cycle -> fifo_count stays 4, move_count increments by 1, overflow stays 0.
REQ-043 Reset asserted mid-SETTLE with 0x09 still held -> all outputs 0; first enqueue occurs 6 edges after reset releases.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube move types and the USB HID keycodes that map onto them.
package cube_pkg;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_D = 3'd1,
        FACE_F = 3'd2,
        FACE_B = 3'd3,
        FACE_L = 3'd4,
        FACE_R = 3'd5
    } face_t;

    typedef struct packed {
        logic  prime;
        face_t face;
    } move_t;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_U    = 8'h18;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_F    = 8'h09;
    localparam logic [7:0] KEY_B    = 8'h05;
    localparam logic [7:0] KEY_L    = 8'h0F;
    localparam logic [7:0] KEY_R    = 8'h15;
    localparam logic [7:0] KEY_P    = 8'h13;
    localparam logic [7:0] KEY_ESC  = 8'h29;

    function automatic logic is_face_key(input logic [7:0] key);
        return (key == KEY_U) || (key == KEY_D) || (key == KEY_F) ||
               (key == KEY_B) || (key == KEY_L) || (key == KEY_R);
    endfunction

    function automatic face_t face_of(input logic [7:0] key);
        face_t f;
        case (key)
            KEY_D:   f = FACE_D;
            KEY_F:   f = FACE_F;
            KEY_B:   f = FACE_B;
            KEY_L:   f = FACE_L;
            KEY_R:   f = FACE_R;
            default: f = FACE_U;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Move queue between the key decoder and the rotation engine; head is read
// straight from storage so it stays stable while the consumer stalls.
module move_fifo
    import cube_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  move_t                      push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output move_t                      head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    move_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keycode_move_decoder.sv
// Debounces raw HID keycodes, turns accepted face/prime/Esc keys into cube
// moves and queues them for the rotation engine.
module keycode_move_decoder
    import cube_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                       clk,
    input  logic                       Reset_h,
    input  logic [7:0]                 keycode,
    output logic                       move_valid,
    input  logic                       move_ready,
    output logic [2:0]                 move_face,
    output logic                       move_prime,
    output logic                       prime_mode,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                move_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_keycode;
    logic [7:0]  r_key, w_key_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        w_accept;
    logic        r_prime_mode;
    logic        r_overflow;
    logic [15:0] r_move_count;

    logic        w_push, w_pop, w_flush, w_toggle;
    logic        w_full, w_empty;
    move_t       w_head;
    move_t       w_push_data;

    always_ff @(posedge clk) begin
        if (Reset_h) begin
            r_state   <= ST_IDLE;
            r_keycode <= KEY_NONE;
            r_key     <= KEY_NONE;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_keycode <= keycode;
            r_key     <= w_key_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Key tracker: r_key is the candidate being qualified; acceptance fires once per press.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_keycode != KEY_NONE) begin
                    w_state_nxt = ST_SETTLE;
                    w_key_nxt   = r_keycode;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (r_keycode == KEY_NONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_keycode != r_key) begin
                    w_key_nxt = r_keycode;
                    w_cnt_nxt = '0;
                end else if (r_cnt == 16'(STABLE_CYCLES - 1)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_HELD: begin
                if (r_keycode == KEY_NONE) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_keycode != r_key) begin
                    w_state_nxt = ST_SETTLE;
                    w_key_nxt   = r_keycode;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_push      = w_accept && is_face_key(r_key);
    assign w_toggle    = w_accept && (r_key == KEY_P);
    assign w_flush     = w_accept && (r_key == KEY_ESC);
    assign w_pop       = move_ready && !w_empty;
    assign w_push_data = '{prime: r_prime_mode, face: face_of(r_key)};

    always_ff @(posedge clk) begin
        if (Reset_h) begin
            r_prime_mode <= 1'b0;
            r_overflow   <= 1'b0;
            r_move_count <= '0;
        end else begin
            if (w_toggle) r_prime_mode <= ~r_prime_mode;
            if (w_flush)
                r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (w_pop) r_move_count <= r_move_count + 16'd1;
        end
    end

    move_fifo #(
        .DEPTH (DEPTH)
    ) u_move_fifo (
        .clk       (clk),
        .rst       (Reset_h),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (w_flush),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count),
        .head      (w_head)
    );

    assign move_valid = !w_empty;
    assign move_face  = w_head.face;
    assign move_prime = w_head.prime;
    assign prime_mode = r_prime_mode;
    assign overflow   = r_overflow;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_keycode_move_decoder.sv
// Directed bench for keycode_move_decoder with STABLE_CYCLES=4, DEPTH=4.
module tb_keycode_move_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        Reset_h;
    logic [7:0]  keycode;
    logic        move_valid;
    logic        move_ready;
    logic [2:0]  move_face;
    logic        move_prime;
    logic        prime_mode;
    logic        overflow;
    logic [2:0]  fifo_count;
    logic [15:0] move_count;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [15:0] exp_mc = '0;

    keycode_move_decoder #(
        .STABLE_CYCLES (STABLE),
        .DEPTH         (DEPTH)
    ) dut (
        .clk        (clk),
        .Reset_h    (Reset_h),
        .keycode    (keycode),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_face  (move_face),
        .move_prime (move_prime),
        .prime_mode (prime_mode),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a key long enough to be accepted, then release it.
    task automatic press(input logic [7:0] key);
        keycode = key;
        tick(STABLE + 2);
        keycode = 8'h00;
        tick(2);
    endtask

    initial begin
        Reset_h    = 1'b1;
        keycode    = 8'h00;
        move_ready = 1'b0;
        tick(2);
        Reset_h = 1'b0;
        check_eq("rst_valid", 32'(move_valid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ovf",   32'(overflow),   32'd0);
        check_eq("rst_prime", 32'(prime_mode), 32'd0);
        check_eq("rst_mc",    32'(move_count), 32'd0);

        // Latency: valid rises on edge STABLE+2 and no autorepeat afterwards.
        keycode = 8'h15;
        tick(5);
        check_eq("lat_before", 32'(move_valid), 32'd0);
        tick(1);
        check_eq("lat_valid", 32'(move_valid), 32'd1);
        check_eq("lat_face",  32'(move_face),  32'd5);
        check_eq("lat_prime", 32'(move_prime), 32'd0);
        tick(4);
        check_eq("no_repeat", 32'(fifo_count), 32'd1);
        keycode = 8'h00;
        tick(2);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        exp_mc++;
        check_eq("pop_count", 32'(fifo_count), 32'd0);
        check_eq("pop_mc",    32'(move_count), 32'(exp_mc));

        // Short glitch is never accepted.
        keycode = 8'h15;
        tick(2);
        keycode = 8'h00;
        tick(10);
        check_eq("glitch_count", 32'(fifo_count), 32'd0);

        // Prime latch applies to later enqueues only.
        press(8'h13);
        check_eq("p_mode", 32'(prime_mode), 32'd1);
        press(8'h18);
        check_eq("p_face",  32'(move_face),  32'd0);
        check_eq("p_prime", 32'(move_prime), 32'd1);
        press(8'h13);
        check_eq("p_mode_off",   32'(prime_mode), 32'd0);
        check_eq("p_head_keeps", 32'(move_prime), 32'd1);
        press(8'h29);
        check_eq("esc_count", 32'(fifo_count), 32'd0);

        // Overflow with six faces into depth 4, then Esc clears it.
        press(8'h18); press(8'h07); press(8'h09);
        press(8'h05); press(8'h0F); press(8'h15);
        check_eq("ovf_count", 32'(fifo_count), 32'd4);
        check_eq("ovf_flag",  32'(overflow),   32'd1);
        check_eq("ovf_head",  32'(move_face),  32'd0);
        press(8'h29);
        check_eq("ovf_esc_count", 32'(fifo_count), 32'd0);
        check_eq("ovf_esc_flag",  32'(overflow),   32'd0);

        // Full FIFO, push and pop in the same cycle.
        press(8'h18); press(8'h07); press(8'h09); press(8'h05);
        keycode = 8'h0F;
        tick(5);
        check_eq("full_pre", 32'(fifo_count), 32'd4);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        exp_mc++;
        check_eq("full_xfer_count", 32'(fifo_count), 32'd4);
        check_eq("full_xfer_mc",    32'(move_count), 32'(exp_mc));
        check_eq("full_xfer_ovf",   32'(overflow),   32'd0);
        keycode = 8'h00;
        tick(2);

        // Drain in order D F B L.
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain_face", 32'(move_face), 32'(i));
            move_ready = 1'b1;
            tick(1);
            move_ready = 1'b0;
            exp_mc++;
        end
        check_eq("drain_count", 32'(fifo_count), 32'd0);
        check_eq("drain_mc",    32'(move_count), 32'(exp_mc));
        move_ready = 1'b1;
        tick(3);
        move_ready = 1'b0;
        check_eq("empty_ready_mc", 32'(move_count), 32'(exp_mc));
        check_eq("empty_valid",    32'(move_valid), 32'd0);

        // Flush and transfer in the same cycle.
        press(8'h15); press(8'h15);
        check_eq("fx_pre", 32'(fifo_count), 32'd2);
        keycode = 8'h29;
        tick(5);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        exp_mc++;
        check_eq("fx_count", 32'(fifo_count), 32'd0);
        check_eq("fx_mc",    32'(move_count), 32'(exp_mc));
        keycode = 8'h00;
        tick(2);

        // Reset mid-SETTLE with F held, then full requalification.
        press(8'h13);
        check_eq("pre_rst_prime", 32'(prime_mode), 32'd1);
        keycode = 8'h09;
        tick(3);
        Reset_h = 1'b1;
        tick(1);
        Reset_h = 1'b0;
        check_eq("mid_rst_valid", 32'(move_valid), 32'd0);
        check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
        check_eq("mid_rst_prime", 32'(prime_mode), 32'd0);
        check_eq("mid_rst_ovf",   32'(overflow),   32'd0);
        check_eq("mid_rst_mc",    32'(move_count), 32'd0);
        tick(5);
        check_eq("requal_early", 32'(fifo_count), 32'd0);
        tick(1);
        check_eq("requal_count", 32'(fifo_count), 32'd1);
        check_eq("requal_face",  32'(move_face),  32'd2);
        check_eq("requal_prime", 32'(move_prime), 32'd0);
        keycode = 8'h00;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
